fram_wb_arbiter: RTL and testbench
==================================

FRAM_WB_ARBITER -- requirements
Module: fram_wb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, word address width of the feature SRAM.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-003 SHALL have parameter BANK_BITS, default 2, low address bits that select the bank.
REQ-004 SHALL have parameter DEPTH, default 4, writeback FIFO depth (power of 2, >=2).
REQ-005 SHALL have parameter STARVE_MAX, default 8, maximum cycles a FIFO head may wait.
REQ-006 SHALL have ports:
  clk  in  1  sole clock.
  rst  in  1  synchronous, active-high reset.
  rd_req  in  1  decoder read request.
  rd_addr  in  ADDR_WIDTH  read word address.
  rd_gnt  out  1  read issued this cycle (combinational).
  rd_rvalid  out  1  read data valid.
  rd_rdata  out  DATA_WIDTH  read data.
  wr_valid  in  1  CU result valid.
  wr_addr  in  ADDR_WIDTH  writeback address.
  wr_data  in  DATA_WIDTH  writeback data.
  wr_ready  out  1  FIFO not full.
  rp_en  out  1  router read enable.
  rp_addr  out  ADDR_WIDTH  router read address.
  rp_rdata  in  DATA_WIDTH  router read data, 1-cycle latency.
  wp_en  out  1  router write enable.
  wp_addr  out  ADDR_WIDTH  router write address.
  wp_wdata  out  DATA_WIDTH  router write data.
  fifo_level  out  log2(DEPTH)+1  FIFO occupancy.
  idle  out  1  FIFO empty and no read in flight.

Function
REQ-007 SHALL push {wr_addr, wr_data} on a clock edge where wr_valid and wr_ready are both 1; wr_ready SHALL be 1 exactly when fifo_level < DEPTH.
REQ-008 SHALL make a pushed entry eligible for issue no earlier than the next cycle (no bypass).
REQ-009 SHALL use bank(a) = a[BANK_BITS-1:0]. rp_en and wp_en SHALL never both be 1 with the same bank.
REQ-010 SHALL implement FSM {RD_PRI, WR_DRAIN}; the reset state is RD_PRI.
REQ-011 RD_PRI: if a read is eligible, it SHALL be issued. The FIFO head SHALL also be issued in the same cycle if no read is issued or the banks differ.
REQ-012 WR_DRAIN: the head SHALL be issued every cycle. A read SHALL also be issued only if it is eligible and its bank differs from the head's bank.
REQ-013 A read is eligible when rd_req=1 and no valid FIFO entry has address equal to rd_addr. This is a RAW hazard; the read stalls and the FIFO drains normally.
REQ-014 FSM transitions:
  RD_PRI->WR_DRAIN when fifo_level==DEPTH or starve_cnt==STARVE_MAX.
  WR_DRAIN->RD_PRI when a pop brings fifo_level to 0.
REQ-015 starve_cnt SHALL increment in each cycle where the FIFO is non-empty and the head is not issued. It SHALL clear on a head issue and saturate at STARVE_MAX.
REQ-016 Head issue: wp_en=1, wp_addr/wp_wdata = head entry, and the entry is popped at that edge.
REQ-017 A simultaneous push and pop SHALL leave fifo_level unchanged, with correct ordering.
REQ-018 Read issue: rp_en=rd_gnt=1 and rp_addr=rd_addr. rd_rvalid SHALL be 1 exactly one cycle later, with rd_rdata=rp_rdata.
REQ-019 The FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-020 idle SHALL be 1 when fifo_level==0 and rd_rvalid is not pending next cycle.

Reset
REQ-021 On rst=1 at a clock edge, the block SHALL:
  - clear FIFO pointers, fifo_level, starve_cnt and rd_rvalid;
  - set the FSM to RD_PRI;
  - discard in-flight entries.
REQ-022 While rst=1, rd_gnt, rp_en and wp_en SHALL be 0, wr_ready SHALL be 0, and idle SHALL be 1.
REQ-023 Reset asserted mid-drain SHALL leave no write issued in the following cycle.

Verification
REQ-024 Same-bank collision: FIFO holds addr 0x004, rd_req addr 0x008 (bank 0), RD_PRI -> rp_en=1, wp_en=0. Then with rd_req=0 the next cycle -> wp_en=1, wp_addr=0x004.
REQ-025 Parallel issue: head 0x005 (bank 1), read 0x008 (bank 0) -> rp_en=1 and wp_en=1 in the same cycle; fifo_level decrements.
REQ-026 Full FIFO: 4 pushes with continuous same-bank reads -> wr_ready=0, FSM=WR_DRAIN. Four writes issue in order on consecutive cycles, then RD_PRI.
REQ-027 Starvation: 1 entry plus same-bank reads every cycle -> head issued at cycle 9 (STARVE_MAX=8), starve_cnt then 0.
REQ-028 RAW hazard: push addr 0x010, next-cycle rd_req addr 0x010 -> rd_gnt=0 until the write issues. The read issues the following cycle and returns the new data.
REQ-029 Reset mid-operation: rst=1 with fifo_level=3 -> next cycle fifo_level=0, wp_en=0, idle=1.

Source files
------------

// File: rtl/fram_wb_arbiter.sv
// Feature-SRAM port arbiter: merges decoder reads with a small writeback FIFO
// onto the router's read and write ports. Reads win by default. The FIFO head
// is drained whenever its bank is free, and is forced out when the FIFO fills
// or its head has waited too long. Reads that hit a queued address stall
// until that write has left the FIFO.
module fram_wb_arbiter #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BANK_BITS  = 2,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_req,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic                    rd_gnt,
    output logic                    rd_rvalid,
    output logic [DATA_WIDTH-1:0]   rd_rdata,
    input  logic                    wr_valid,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    wr_ready,
    output logic                    rp_en,
    output logic [ADDR_WIDTH-1:0]   rp_addr,
    input  logic [DATA_WIDTH-1:0]   rp_rdata,
    output logic                    wp_en,
    output logic [ADDR_WIDTH-1:0]   wp_addr,
    output logic [DATA_WIDTH-1:0]   wp_wdata,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    idle
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

    localparam logic [0:0] RD_PRI   = 1'b0;
    localparam logic [0:0] WR_DRAIN = 1'b1;

    // FIFO storage; a per-slot valid bit lets the hazard check ignore stale slots
    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]      valid_q;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic [0:0]       state_q, state_d;
    logic             rvalid_q;

    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  starve_sat;
    logic                  hazard;
    logic                  rd_elig;
    logic                  banks_differ;
    logic                  rd_issue;
    logic                  wr_issue;
    logic                  push;
    logic                  pop;

    assign head_addr    = addr_mem[rd_ptr_q];
    assign head_data    = data_mem[rd_ptr_q];
    assign fifo_empty   = (level_q == '0);
    assign fifo_full    = (level_q == LVL_W'(DEPTH));
    assign starve_sat   = (starve_q == STV_W'(STARVE_MAX));
    assign banks_differ = (rd_addr[BANK_BITS-1:0] != head_addr[BANK_BITS-1:0]);
    assign rd_elig      = rd_req && !hazard;

    // RAW hazard: the read address matches any write still waiting in the FIFO
    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_mem[i] == rd_addr)) begin
                hazard = 1'b1;
            end
        end
    end

    // Port issue decision; nothing is issued while reset is held
    always_comb begin
        rd_issue = 1'b0;
        wr_issue = 1'b0;
        if (!rst) begin
            if (state_q == RD_PRI) begin
                rd_issue = rd_elig;
                wr_issue = !fifo_empty && (!rd_elig || banks_differ);
            end else begin
                wr_issue = !fifo_empty;
                rd_issue = rd_elig && (fifo_empty || banks_differ);
            end
        end
    end

    assign push = wr_valid && wr_ready;
    assign pop  = wr_issue;

    // FIFO pointer, occupancy and starvation bookkeeping
    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end

        starve_d = starve_q;
        if (wr_issue) begin
            starve_d = '0;
        end else if (!fifo_empty && !starve_sat) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    // Mode selection: fall into drain when full or starved, leave once empty
    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_PRI: begin
                if (fifo_full || starve_sat) begin
                    state_d = WR_DRAIN;
                end
            end
            WR_DRAIN: begin
                if (pop && (level_d == '0)) begin
                    state_d = RD_PRI;
                end
            end
            default: state_d = RD_PRI;
        endcase
    end

    // Control state with synchronous reset; in-flight entries are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            starve_q <= '0;
            state_q  <= RD_PRI;
            rvalid_q <= 1'b0;
            valid_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            starve_q <= starve_d;
            state_q  <= state_d;
            rvalid_q <= rd_issue;
            // Push and pop never share a slot: a full FIFO refuses pushes
            if (pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
            end
            if (push) begin
                valid_q[wr_ptr_q] <= 1'b1;
            end
        end
    end

    // FIFO payload storage, qualified by valid_q so it needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= wr_addr;
            data_mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_gnt     = rd_issue;
    assign rp_en      = rd_issue;
    assign rp_addr    = rd_addr;
    assign wp_en      = wr_issue;
    assign wp_addr    = head_addr;
    assign wp_wdata   = head_data;
    assign wr_ready   = !rst && !fifo_full;
    assign rd_rvalid  = rvalid_q;
    // Router read has one cycle of latency, so its data lines up with rvalid_q
    assign rd_rdata   = rp_rdata;
    assign fifo_level = level_q;
    assign idle       = rst || (fifo_empty && !rd_issue);

endmodule

// File: tb/tb_fram_wb_arbiter.sv
// Bench for fram_wb_arbiter: a queue-based reference model predicts every
// cycle's port decisions and pushes expected writes and read data into
// scoreboard queues that a separate monitor drains as the DUT responds.
module tb_fram_wb_arbiter;

    localparam int unsigned AW    = 14;
    localparam int unsigned DW    = 32;
    localparam int unsigned BB    = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SMAX  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_gnt;
    logic          rd_rvalid;
    logic [DW-1:0] rd_rdata;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          rp_en;
    logic [AW-1:0] rp_addr;
    logic [DW-1:0] rp_rdata = '0;
    logic          wp_en;
    logic [AW-1:0] wp_addr;
    logic [DW-1:0] wp_wdata;
    logic [2:0]    fifo_level;
    logic          idle;

    always #5 clk = ~clk;

    fram_wb_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .BANK_BITS (BB),
        .DEPTH     (DEPTH),
        .STARVE_MAX(SMAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_rvalid (rd_rvalid),
        .rd_rdata  (rd_rdata),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rp_en     (rp_en),
        .rp_addr   (rp_addr),
        .rp_rdata  (rp_rdata),
        .wp_en     (wp_en),
        .wp_addr   (wp_addr),
        .wp_wdata  (wp_wdata),
        .fifo_level(fifo_level),
        .idle      (idle)
    );

    // Router SRAM stand-in with one-cycle read latency
    logic [DW-1:0] ram [64] = '{default: '0};
    always @(posedge clk) begin
        if (rp_en) rp_rdata <= ram[rp_addr[5:0]];
        if (wp_en) ram[wp_addr[5:0]] <= wp_wdata;
    end

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    ent_t          exp_wr_q[$];
    logic [DW-1:0] exp_rd_q[$];
    logic [DW-1:0] ref_mem [64];
    bit            drain;
    int            starve;
    int            checks;
    int            errors;
    bit            mon_on;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one call per cycle, after inputs have settled
    task automatic model_eval();
        bit   rd, wr, hz, same_bank, push;
        int   lvl;
        ent_t h, e;
        if (rst) begin
            chk("rst_rd_gnt", rd_gnt, 0);
            chk("rst_rp_en", rp_en, 0);
            chk("rst_wp_en", wp_en, 0);
            chk("rst_wr_ready", wr_ready, 0);
            chk("rst_idle", idle, 1);
            q.delete();
            drain  = 0;
            starve = 0;
            return;
        end
        lvl = q.size();
        hz = 0;
        foreach (q[i]) if (q[i].a == rd_addr) hz = 1;
        same_bank = (lvl > 0) && (q[0].a[BB-1:0] == rd_addr[BB-1:0]);
        if (!drain) begin
            rd = rd_req && !hz;
            wr = (lvl > 0) && (!rd || !same_bank);
        end else begin
            wr = (lvl > 0);
            rd = rd_req && !hz && !same_bank;
        end
        push = wr_valid && (lvl < DEPTH);

        chk("rd_gnt", rd_gnt, rd);
        chk("rp_en", rp_en, rd);
        chk("wp_en", wp_en, wr);
        chk("wr_ready", wr_ready, lvl < DEPTH);
        chk("fifo_level", fifo_level, lvl);
        chk("idle", idle, (lvl == 0) && !rd);
        if (rd) begin
            chk("rp_addr", rp_addr, rd_addr);
            exp_rd_q.push_back(ref_mem[rd_addr[5:0]]);
        end
        if (wr) exp_wr_q.push_back(q[0]);

        if (!drain && (lvl == DEPTH || starve == SMAX)) drain = 1;
        else if (drain && wr && lvl == 1 && !push) drain = 0;

        if (wr) begin
            h = q[0];
            ref_mem[h.a[5:0]] = h.d;
            q.delete(0);
            starve = 0;
        end else if (lvl > 0 && starve < SMAX) begin
            starve++;
        end
        if (push) begin
            e.a = wr_addr;
            e.d = wr_data;
            q.push_back(e);
        end
    endtask

    task automatic step(input bit r, input bit rq, input int ra, input bit wv, input int wa,
                        input logic [DW-1:0] wd);
        @(negedge clk);
        rst      = r;
        rd_req   = rq;
        rd_addr  = AW'(ra);
        wr_valid = wv;
        wr_addr  = AW'(wa);
        wr_data  = wd;
        #1;
        model_eval();
    endtask

    // Monitor: consumes scoreboard entries whenever the DUT presents a write or read data
    initial begin
        ent_t          e;
        logic [DW-1:0] d;
        forever begin
            @(negedge clk);
            #3;
            if (mon_on) begin
                if (wp_en) begin
                    chk("wp_en_vs_queue", wp_en, exp_wr_q.size() != 0);
                    if (exp_wr_q.size() != 0) begin
                        e = exp_wr_q.pop_front();
                        chk("wp_addr", wp_addr, e.a);
                        chk("wp_wdata", wp_wdata, e.d);
                    end
                end
                if (rd_rvalid) begin
                    chk("rvalid_vs_queue", rd_rvalid, exp_rd_q.size() != 0);
                    if (exp_rd_q.size() != 0) begin
                        d = exp_rd_q.pop_front();
                        chk("rd_rdata", rd_rdata, d);
                    end
                end
            end
        end
    end

    initial begin
        int a26[4];
        int first;
        a26 = '{'h000, 'h004, 'h00c, 'h010};
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        checks = 0;
        errors = 0;
        mon_on = 0;

        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        mon_on = 1;

        // Same-bank collision: read wins, write follows once the read goes away
        step(0, 0, 0, 1, 'h004, 32'h0000_00a0);
        step(0, 1, 'h008, 0, 0, 0);
        chk("s024_rp_en", rp_en, 1);
        chk("s024_wp_en", wp_en, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("s024_wp_en_next", wp_en, 1);
        chk("s024_wp_addr", wp_addr, 'h004);

        // Parallel issue on different banks
        step(0, 0, 0, 1, 'h005, 32'h0000_00b1);
        step(0, 1, 'h008, 0, 0, 0);
        chk("s025_rp_en", rp_en, 1);
        chk("s025_wp_en", wp_en, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("s025_level", fifo_level, 0);

        // Fill the FIFO behind same-bank reads, then drain in order
        for (int i = 0; i < 4; i++) step(0, 1, 'h008, 1, a26[i], $urandom);
        step(0, 1, 'h008, 1, 'h014, $urandom);
        chk("s026_wr_ready", wr_ready, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 'h008, 0, 0, 0);
            chk("s026_drain_en", wp_en, 1);
            chk("s026_drain_addr", wp_addr, AW'(a26[i]));
        end
        step(0, 1, 'h008, 0, 0, 0);
        chk("s026_back_to_read", rp_en, 1);

        // Starvation: one entry blocked by same-bank reads every cycle
        step(0, 0, 0, 1, 'h004, 32'h0000_0027);
        first = -1;
        for (int k = 0; k < 12; k++) begin
            step(0, 1, 'h008, 0, 0, 0);
            if (wp_en && first < 0) first = k;
        end
        chk("s027_issue_cycle", first, 9);

        // RAW hazard: read stalls until the write leaves, then sees new data
        step(0, 0, 0, 1, 'h010, 32'h00c0_ffee);
        step(0, 1, 'h010, 0, 0, 0);
        chk("s028_stall", rd_gnt, 0);
        step(0, 1, 'h010, 0, 0, 0);
        chk("s028_grant", rd_gnt, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("s028_rvalid", rd_rvalid, 1);
        chk("s028_rdata", rd_rdata, 32'h00c0_ffee);

        // Reset with three queued writes
        step(0, 1, 'h008, 1, 'h000, $urandom);
        step(0, 1, 'h008, 1, 'h004, $urandom);
        step(0, 1, 'h008, 1, 'h00c, $urandom);
        step(0, 1, 'h008, 0, 0, 0);
        chk("s029_level_pre", fifo_level, 3);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("s029_level", fifo_level, 0);
        chk("s029_wp_en", wp_en, 0);
        chk("s029_idle", idle, 1);

        // Reset in the middle of a forced drain
        for (int i = 0; i < 4; i++) step(0, 1, 'h008, 1, a26[i], $urandom);
        step(0, 1, 'h008, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("s023_draining", wp_en, 1);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("s023_no_write", wp_en, 0);

        // Randomized traffic over a small address space to provoke hazards and collisions
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(99) == 0, $urandom_range(9) < 6, $urandom_range(31),
                 $urandom_range(1) == 1, $urandom_range(31), $urandom);
        end

        for (int n = 0; n < 12; n++) step(0, 0, 0, 0, 0, 0);
        chk("wr_queue_drained", exp_wr_q.size(), 0);
        chk("rd_queue_drained", exp_rd_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
